// File: rtl/alsu_result_collector_if.sv
// rtl/alsu_result_collector_if.sv - ALSU result capture / FIFO drain bus (ALSU_COLLECT_PARITY_EN adds parity)
interface alsu_result_collector_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
`ifdef ALSU_COLLECT_PARITY_EN
    localparam int DATA_W = 8;
`else
    localparam int DATA_W = 7;
`endif

    logic                     in_valid;
    logic [5:0]               out;
    logic [15:0]              leds;
    logic                     clr;
    logic                     rd_en;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [CNT_W-1:0]         invalid_cnt;
`ifdef ALSU_COLLECT_PARITY_EN
    logic                     parity_err;
`endif

    modport slave (
        input  in_valid, out, leds, clr, rd_en,
        output rd_data, rd_valid, empty, full, count, overflow, invalid_cnt
`ifdef ALSU_COLLECT_PARITY_EN
        , parity_err
`endif
    );

    modport master (
        output in_valid, out, leds, clr, rd_en,
        input  rd_data, rd_valid, empty, full, count, overflow, invalid_cnt
`ifdef ALSU_COLLECT_PARITY_EN
        , parity_err
`endif
    );
endinterface

// File: rtl/alsu_result_collector.sv
// rtl/alsu_result_collector.sv - aligns ALSU results to their input cycle and queues them (ALSU_COLLECT_PARITY_EN adds entry parity)
module alsu_result_collector #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    alsu_result_collector_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef ALSU_COLLECT_PARITY_EN
    localparam int EW = 8;
`else
    localparam int EW = 7;
`endif

    logic [LATENCY-1:0] pipe;
    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        occ;
    logic [EW-1:0]      rd_data_q;
    logic               rd_valid_q;
    logic               overflow_q;
    logic [CNT_W-1:0]   invalid_cnt_q;

    logic               cap;
    logic               inv;
    logic               full_w;
    logic               empty_w;
    logic               pop_ok;
    logic               push_ok;
    logic               drop;
    logic [EW-1:0]      entry;

    assign cap     = pipe[LATENCY-1];
    assign inv     = |bus.leds;
    assign full_w  = (occ == (AW+1)'(DEPTH));
    assign empty_w = (occ == '0);
    assign pop_ok  = bus.rd_en && !empty_w;
    // A full FIFO still accepts a capture when a pop frees a slot on the same edge.
    assign push_ok = cap && (!full_w || pop_ok);
    assign drop    = cap && full_w && !pop_ok;

`ifdef ALSU_COLLECT_PARITY_EN
    logic parity_err_q;
    assign entry          = {^{inv, bus.out}, inv, bus.out};
    assign bus.parity_err = parity_err_q;
`else
    assign entry = {inv, bus.out};
`endif

    always_ff @(posedge clk) begin
        if (push_ok && !bus.clr) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe          <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            overflow_q    <= 1'b0;
            invalid_cnt_q <= '0;
`ifdef ALSU_COLLECT_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            // The alignment pipe keeps running through clr so in-flight samples still land.
            pipe <= (pipe << 1) | LATENCY'(bus.in_valid);
            if (bus.clr) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                occ           <= '0;
                rd_valid_q    <= 1'b0;
                overflow_q    <= 1'b0;
                invalid_cnt_q <= '0;
`ifdef ALSU_COLLECT_PARITY_EN
                parity_err_q  <= 1'b0;
`endif
            end else begin
                rd_valid_q <= pop_ok;
`ifdef ALSU_COLLECT_PARITY_EN
                parity_err_q <= pop_ok && (^mem[rd_ptr]);
`endif
                if (pop_ok) begin
                    rd_data_q <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + AW'(1);
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (inv && (invalid_cnt_q != {CNT_W{1'b1}})) begin
                        invalid_cnt_q <= invalid_cnt_q + CNT_W'(1);
                    end
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
                case ({push_ok, pop_ok})
                    2'b10:   occ <= occ + (AW+1)'(1);
                    2'b01:   occ <= occ - (AW+1)'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.count       = occ;
    assign bus.overflow    = overflow_q;
    assign bus.invalid_cnt = invalid_cnt_q;
endmodule

// File: doc/alsu_result_collector.md
Name: alsu_result_collector

Overview:
- Downstream stage of the ALSU. Aligns the ALSU's registered `out`/`leds` with the cycle its inputs were applied.
- Captures each valid result into a small FIFO for a host/bench to drain.
- Keeps a saturating count of invalid-operation results, flagged by non-zero `leds`.
- Sits between the ALSU DUT outputs and the reporting/scoreboard logic.

Parameters:
- LATENCY, 2, cycles from ALSU input sample to valid `out`/`leds`; legal 1..4.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CNT_W, 8, width of the invalid-result counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  high in the cycle ALSU inputs (opcode, A, B, ...) are presented.
- out  input  6  ALSU result.
- leds  input  16  ALSU LED bus; non-zero means invalid operation.
- clr  input  1  synchronous clear of FIFO, overflow flag and counter.
- rd_en  input  1  pop request.
- rd_data  output  7  popped entry {invalid, out[5:0]} (8 bits with parity option).
- rd_valid  output  1  rd_data valid, one cycle after an accepted pop.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a capture was dropped.
- invalid_cnt  output  CNT_W  number of invalid results captured, saturating.

Behaviour:
- Reset (asynchronous, rst=1): clears the alignment pipe, FIFO pointers and all outputs.
  - rd_data=0, rd_valid=0, empty=1, full=0, count=0, overflow=0, invalid_cnt=0.
  - Reset asserted mid-stream discards all in-flight valids and stored entries.
- Alignment pipe: LATENCY-deep shift register of in_valid.
  - cap = pipe[LATENCY-1].
  - When cap=1, the current `out` and `leds` are the result for that sample.
- Capture: when cap=1, entry = {inv, out}, where inv = (leds != 0).
  - Written at the rising edge of the cap cycle if the FIFO is not full, or if a pop is accepted in the same cycle.
- Pop: accepted when rd_en=1 and empty=0.
  - rd_data is registered from the head entry at that edge.
  - rd_valid=1 the following cycle, 0 otherwise.
  - rd_data holds its last value when no pop occurs.
  - rd_en while empty is ignored: rd_valid stays 0, no pointer change.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the push succeeds because a slot frees in the same cycle.
  - When empty, the pop is ignored and the push proceeds; no fall-through.
- Overflow: cap=1 while full with no accepted pop drops the entry and sets overflow=1. It stays set until clr or rst.
- invalid_cnt: increments when an entry with inv=1 is written; dropped entries do not count. Saturates at 2^CNT_W-1, no wrap.
- Pointers: $clog2(DEPTH)-bit, wrap modulo DEPTH. full = (count == DEPTH); empty = (count == 0).
- clr=1:
  - Next edge empties the FIFO and zeroes overflow and invalid_cnt. The pipe contents are kept.
  - Any capture and pop in that cycle are discarded.
  - Has priority over push/pop, below rst.
- `out` is treated as unsigned raw bits; no sign handling.

Optional Feature:
- Macro: ALSU_COLLECT_PARITY_EN.
- Defined:
  - Each entry gains bit 7 = even parity over {inv, out[5:0]}, so rd_data is 8 bits.
  - An extra output parity_err (1 bit) pulses for one cycle alongside rd_valid when the stored parity mismatches the recomputed parity.
  - parity_err must be 0 in normal operation; it catches storage corruption.
- Not defined: rd_data is 7 bits and no parity_err port exists.

Test Plan:
- Reset then single capture (LATENCY=2):
  - Stimulus: in_valid pulse at cycle 0; out=6'h15, leds=0 at cycle 2; rd_en at cycle 4.
  - Response: count=1 after cycle 2; rd_data=7'h15 and rd_valid=1 at cycle 5; empty=1.
- Invalid result: cap with out=0, leds=16'hFFFF -> entry 7'h40, invalid_cnt=1.
- Fill to full: 8 captures, out=0..7, no reads.
  - Response: full=1, count=8.
  - A 9th capture sets overflow=1 and count stays 8.
  - Draining returns 0..7 in order.
- Push and pop while full: capture out=6'h2A with rd_en=1.
  - Response: count stays 8, overflow stays 0, the last pop yields 7'h2A.
- Counter saturation (CNT_W=8): 300 invalid captures drained continuously -> invalid_cnt=255.
- Clear and reset mid-stream:
  - clr with 3 entries -> count=0, overflow=0, invalid_cnt=0 next cycle.
  - rst pulse with in_valid in flight -> no capture appears after reset release.
